// File: rtl/time_set_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | time_set_ctrl : hour/min/sec edit sequencer with blink and load pulse |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module time_set_ctrl #(
    parameter int TIMEOUT_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_blink,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_hour_tens,
    input  logic [3:0] cur_hour_units,
    input  logic [3:0] cur_min_tens,
    input  logic [3:0] cur_min_units,
    input  logic [3:0] cur_sec_tens,
    input  logic [3:0] cur_sec_units,
    output logic [3:0] set_hour_tens,
    output logic [3:0] set_hour_units,
    output logic [3:0] set_min_tens,
    output logic [3:0] set_min_units,
    output logic [3:0] set_sec_tens,
    output logic [3:0] set_sec_units,
    output logic       load,
    output logic       editing,
    output logic [5:0] ena
);

    localparam logic [1:0] c_st_run  = 2'd0;
    localparam logic [1:0] c_st_hour = 2'd1;
    localparam logic [1:0] c_st_min  = 2'd2;
    localparam logic [1:0] c_st_sec  = 2'd3;
    localparam logic [7:0] c_timeout = 8'(TIMEOUT_TICKS);

    logic [1:0]  r_state, w_state_nxt;
    logic        r_blink, w_blink_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [23:0] r_time, w_time_nxt;
    logic        w_load_nxt;
    logic [5:0]  w_ena_nxt;

    // Any out-of-range or non-BCD pair wraps to 00, which also normalises junk captures.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v[3:0] > 4'd9 || v[7:4] > max[7:4] ||
            (v[7:4] == max[7:4] && v[3:0] >= max[3:0]))
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign w_cnt_inc = r_cnt + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_blink_nxt = r_blink;
        w_cnt_nxt   = r_cnt;
        w_time_nxt  = r_time;
        w_load_nxt  = 1'b0;
        if (r_state == c_st_run) begin
            w_blink_nxt = 1'b1;
            w_cnt_nxt   = 8'd0;
            if (btn_mode) begin
                w_state_nxt = c_st_hour;
                w_time_nxt  = {cur_hour_tens, cur_hour_units, cur_min_tens,
                               cur_min_units, cur_sec_tens, cur_sec_units};
            end
        end else if (btn_mode) begin
            w_cnt_nxt   = 8'd0;
            w_blink_nxt = 1'b1;
            case (r_state)
                c_st_hour: w_state_nxt = c_st_min;
                c_st_min:  w_state_nxt = c_st_sec;
                default: begin
                    w_state_nxt = c_st_run;
                    w_load_nxt  = 1'b1;
                end
            endcase
        end else if (btn_inc) begin
            w_cnt_nxt   = 8'd0;
            w_blink_nxt = 1'b1;
            case (r_state)
                c_st_hour: w_time_nxt[23:16] = bcd_inc(r_time[23:16], 8'h23);
                c_st_min:  w_time_nxt[15:8]  = bcd_inc(r_time[15:8], 8'h59);
                default:   w_time_nxt[7:0]   = bcd_inc(r_time[7:0], 8'h59);
            endcase
        end else if (tick_blink) begin
            if (w_cnt_inc >= c_timeout) begin
                w_state_nxt = c_st_run;
                w_cnt_nxt   = 8'd0;
                w_blink_nxt = 1'b1;
            end else begin
                w_cnt_nxt   = w_cnt_inc;
                w_blink_nxt = ~r_blink;
            end
        end
    end

    always_comb begin
        w_ena_nxt = 6'b111111;
        case (w_state_nxt)
            c_st_hour: w_ena_nxt[5:4] = {2{w_blink_nxt}};
            c_st_min:  w_ena_nxt[3:2] = {2{w_blink_nxt}};
            c_st_sec:  w_ena_nxt[1:0] = {2{w_blink_nxt}};
            default:   w_ena_nxt      = 6'b111111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_run;
            r_blink <= 1'b1;
            r_cnt   <= 8'd0;
            r_time  <= 24'd0;
            load    <= 1'b0;
            editing <= 1'b0;
            ena     <= 6'b111111;
        end else begin
            r_state <= w_state_nxt;
            r_blink <= w_blink_nxt;
            r_cnt   <= w_cnt_nxt;
            r_time  <= w_time_nxt;
            load    <= w_load_nxt;
            editing <= (w_state_nxt != c_st_run);
            ena     <= w_ena_nxt;
        end
    end

    assign set_hour_tens  = r_time[23:20];
    assign set_hour_units = r_time[19:16];
    assign set_min_tens   = r_time[15:12];
    assign set_min_units  = r_time[11:8];
    assign set_sec_tens   = r_time[7:4];
    assign set_sec_units  = r_time[3:0];

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_time_set_ctrl : vector table, corner sequences and random vs model |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_time_set_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_blink, btn_mode, btn_inc;
    logic [23:0] cur_time;
    logic [3:0]  sht, shu, smt, smu, sst, ssu;
    logic        load, editing;
    logic [5:0]  ena;
    logic [23:0] set_all;

    assign set_all = {sht, shu, smt, smu, sst, ssu};

    time_set_ctrl #(.TIMEOUT_TICKS(TO)) dut (
        .clk(clk), .rst(rst), .tick_blink(tick_blink),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hour_tens(cur_time[23:20]), .cur_hour_units(cur_time[19:16]),
        .cur_min_tens(cur_time[15:12]),  .cur_min_units(cur_time[11:8]),
        .cur_sec_tens(cur_time[7:4]),    .cur_sec_units(cur_time[3:0]),
        .set_hour_tens(sht), .set_hour_units(shu),
        .set_min_tens(smt),  .set_min_units(smu),
        .set_sec_tens(sst),  .set_sec_units(ssu),
        .load(load), .editing(editing), .ena(ena)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: mode 0=run,1=hour,2=min,3=sec; digits kept as plain integers.
    int mm;
    int dig[6];
    bit phase;
    int idle;
    bit e_load;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mm = 0; phase = 1'b1; idle = 0; e_load = 1'b0;
        for (int k = 0; k < 6; k++) dig[k] = 0;
    endtask

    task automatic bump(input int f);
        int v, lim;
        lim = (f == 0) ? 24 : 60;
        v = dig[2*f] * 10 + dig[2*f+1];
        if (dig[2*f+1] > 9 || v >= lim - 1) v = 0;
        else v = v + 1;
        dig[2*f]   = v / 10;
        dig[2*f+1] = v % 10;
    endtask

    task automatic model_step(input bit m, input bit i, input bit t);
        e_load = 1'b0;
        if (mm == 0) begin
            if (m) begin
                mm = 1; phase = 1'b1; idle = 0;
                for (int k = 0; k < 6; k++) dig[k] = int'(cur_time[23-4*k -: 4]);
            end
        end else if (m) begin
            idle = 0; phase = 1'b1;
            if (mm == 3) begin mm = 0; e_load = 1'b1; end
            else mm = mm + 1;
        end else if (i) begin
            idle = 0; phase = 1'b1;
            bump(mm - 1);
        end else if (t) begin
            idle = idle + 1;
            if (idle == TO) begin mm = 0; idle = 0; phase = 1'b1; end
            else phase = ~phase;
        end
    endtask

    function automatic logic [23:0] model_set();
        logic [23:0] s;
        for (int k = 0; k < 6; k++) s[23-4*k -: 4] = 4'(dig[k]);
        return s;
    endfunction

    function automatic logic [5:0] model_ena();
        if (mm == 0 || phase) return 6'h3F;
        return 6'h3F & ~(6'd3 << (2 * (3 - mm)));
    endfunction

    task automatic step(input bit m, input bit i, input bit t);
        btn_mode = m; btn_inc = i; tick_blink = t;
        model_step(m, i, t);
        @(posedge clk);
        #1;
        btn_mode = 1'b0; btn_inc = 1'b0; tick_blink = 1'b0;
        chk("model_set", set_all, model_set());
        chk("model_ena", ena, model_ena());
        chk("model_load", load, e_load);
        chk("model_editing", editing, (mm != 0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    typedef struct {
        bit          m, i, t;
        logic [23:0] set;
        logic [5:0]  ena;
        bit          load, ed;
    } vec_t;

    vec_t tbl[14];
    int   loads;

    initial begin
        tbl[0]  = '{0, 0, 0, 24'h000000, 6'h3F, 0, 0};
        tbl[1]  = '{0, 1, 0, 24'h000000, 6'h3F, 0, 0};
        tbl[2]  = '{1, 0, 0, 24'h123456, 6'h3F, 0, 1};
        tbl[3]  = '{0, 1, 0, 24'h133456, 6'h3F, 0, 1};
        tbl[4]  = '{0, 0, 1, 24'h133456, 6'h0F, 0, 1};
        tbl[5]  = '{0, 0, 1, 24'h133456, 6'h3F, 0, 1};
        tbl[6]  = '{0, 1, 0, 24'h143456, 6'h3F, 0, 1};
        tbl[7]  = '{1, 1, 0, 24'h143456, 6'h3F, 0, 1};
        tbl[8]  = '{0, 0, 1, 24'h143456, 6'h33, 0, 1};
        tbl[9]  = '{0, 1, 0, 24'h143556, 6'h3F, 0, 1};
        tbl[10] = '{1, 0, 0, 24'h143556, 6'h3F, 0, 1};
        tbl[11] = '{0, 0, 1, 24'h143556, 6'h3C, 0, 1};
        tbl[12] = '{1, 0, 0, 24'h143556, 6'h3F, 1, 0};
        tbl[13] = '{0, 0, 0, 24'h143556, 6'h3F, 0, 0};

        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; tick_blink = 1'b0;
        cur_time = 24'h123456;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_set", set_all, 24'h000000);
        chk("reset_ena", ena, 6'h3F);
        chk("reset_load", load, 1'b0);
        chk("reset_editing", editing, 1'b0);
        rst = 1'b0;

        for (int v = 0; v < 14; v++) begin
            step(tbl[v].m, tbl[v].i, tbl[v].t);
            chk($sformatf("tbl%0d_set", v), set_all, tbl[v].set);
            chk($sformatf("tbl%0d_ena", v), ena, tbl[v].ena);
            chk($sformatf("tbl%0d_load", v), load, tbl[v].load);
            chk($sformatf("tbl%0d_editing", v), editing, tbl[v].ed);
        end

        // Twelve increments from 12 pass 23 and land on 00; exit yields one load.
        do_reset();
        cur_time = 24'h123456;
        step(1, 0, 0);
        for (int k = 0; k < 12; k++) step(0, 1, 0);
        chk("hour_wrap_23_00", set_all[23:16], 8'h00);
        loads = 0;
        for (int k = 0; k < 3; k++) begin step(1, 0, 0); loads += int'(load); end
        for (int k = 0; k < 3; k++) begin step(0, 0, 0); loads += int'(load); end
        chk("single_load_count", loads, 1);
        chk("after_load_set", set_all, 24'h003456);

        // Carry wraps: 09->10 hours, 58->59->00 minutes, 19->20 hours.
        cur_time = 24'h095800;
        step(1, 0, 0);
        step(0, 1, 0);
        chk("hour_09_10", set_all[23:16], 8'h10);
        step(1, 0, 0);
        step(0, 1, 0);
        chk("min_58_59", set_all[15:8], 8'h59);
        step(0, 1, 0);
        chk("min_59_00", set_all[15:8], 8'h00);
        chk("min_wrap_hour_kept", set_all[23:16], 8'h10);
        step(1, 0, 0); step(1, 0, 0);
        cur_time = 24'h190000;
        step(1, 0, 0);
        step(0, 1, 0);
        chk("hour_19_20", set_all[23:16], 8'h20);
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);

        // Timeout abandons the edit without a load pulse.
        cur_time = 24'h123456;
        step(1, 0, 0); step(1, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 1);
        chk("pre_timeout_editing", editing, 1'b1);
        step(0, 0, 1);
        chk("timeout_editing", editing, 1'b0);
        chk("timeout_load", load, 1'b0);
        chk("timeout_ena", ena, 6'h3F);
        // Press on the terminal tick wins over the timeout.
        step(1, 0, 0); step(1, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 1);
        step(0, 1, 1);
        chk("press_beats_timeout_editing", editing, 1'b1);
        chk("press_beats_timeout_min", set_all[15:8], 8'h35);
        chk("press_beats_timeout_ena", ena, 6'h3F);
        step(0, 0, 1);
        chk("count_restarted", editing, 1'b1);

        // Blink in SET_SEC, then an increment re-lights the digits.
        step(1, 0, 0);
        step(0, 0, 1); chk("blink_sec_1", ena, 6'h3C);
        step(0, 0, 1); chk("blink_sec_2", ena, 6'h3F);
        step(0, 0, 1); chk("blink_sec_3", ena, 6'h3C);
        step(0, 1, 0); chk("blink_inc_forces_on", ena, 6'h3F);
        step(0, 0, 1); chk("blink_sec_4", ena, 6'h3C);

        // Asynchronous reset mid-edit.
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_set", set_all, 24'h000000);
        chk("midreset_ena", ena, 6'h3F);
        chk("midreset_load", load, 1'b0);
        chk("midreset_editing", editing, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0);
        chk("post_reset_load", load, 1'b0);

        // Randomised traffic, including non-BCD captures.
        for (int c = 0; c < 3000; c++) begin
            cur_time = 24'($urandom);
            step($urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
